// File: rtl/ins_encoder.sv
// Instruction assembler / program loader: turns one-hot opcode beats plus operand
// fields into MIPS words and writes them sequentially into imem from address 0.
module ins_encoder #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       code,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   ins_count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {StIdle, StLoad, StDone, StErr} state_e;

    localparam logic [ADDR_W:0] DepthW = DEPTH[ADDR_W:0];

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              legal;
    logic              accept;
    logic [31:0]       enc;

    function automatic logic [31:0] r_word(logic [4:0] s, logic [4:0] t, logic [4:0] d,
                                           logic [4:0] sh, logic [5:0] fn);
        return {6'b000000, s, t, d, sh, fn};
    endfunction

    // Exactly one bit set, and that bit is not the reserved bit 31.
    assign legal = (code != 32'd0) && ((code & (code - 32'd1)) == 32'd0) && !code[31];

    always_comb begin
        enc = 32'd0;
        if (legal) begin
            unique case (1'b1)
                code[0]:  enc = r_word(rs, rt, rd, 5'd0, 6'h20);
                code[1]:  enc = r_word(rs, rt, rd, 5'd0, 6'h21);
                code[2]:  enc = r_word(rs, rt, rd, 5'd0, 6'h22);
                code[3]:  enc = r_word(rs, rt, rd, 5'd0, 6'h23);
                code[4]:  enc = r_word(rs, rt, rd, 5'd0, 6'h24);
                code[5]:  enc = r_word(rs, rt, rd, 5'd0, 6'h25);
                code[6]:  enc = r_word(rs, rt, rd, 5'd0, 6'h26);
                code[7]:  enc = r_word(rs, rt, rd, 5'd0, 6'h27);
                code[8]:  enc = r_word(rs, rt, rd, 5'd0, 6'h2a);
                code[9]:  enc = r_word(rs, rt, rd, 5'd0, 6'h2b);
                code[10]: enc = r_word(5'd0, rt, rd, shamt, 6'h00);
                code[11]: enc = r_word(5'd0, rt, rd, shamt, 6'h02);
                code[12]: enc = r_word(5'd0, rt, rd, shamt, 6'h03);
                code[13]: enc = r_word(rs, rt, rd, 5'd0, 6'h04);
                code[14]: enc = r_word(rs, rt, rd, 5'd0, 6'h06);
                code[15]: enc = r_word(rs, rt, rd, 5'd0, 6'h07);
                code[16]: enc = r_word(rs, 5'd0, 5'd0, 5'd0, 6'h08);
                code[17]: enc = {6'h08, rs, rt, imm};
                code[18]: enc = {6'h09, rs, rt, imm};
                code[19]: enc = {6'h0c, rs, rt, imm};
                code[20]: enc = {6'h0d, rs, rt, imm};
                code[21]: enc = {6'h0e, rs, rt, imm};
                code[22]: enc = {6'h23, rs, rt, imm};
                code[23]: enc = {6'h2b, rs, rt, imm};
                code[24]: enc = {6'h04, rs, rt, imm};
                code[25]: enc = {6'h05, rs, rt, imm};
                code[26]: enc = {6'h0a, rs, rt, imm};
                code[27]: enc = {6'h0b, rs, rt, imm};
                code[28]: enc = {6'h0f, 5'd0, rt, imm};
                code[29]: enc = {6'h02, target};
                code[30]: enc = {6'h03, target};
                default:  enc = 32'd0;
            endcase
        end
    end

    assign in_ready = (state_q == StLoad) && (count_q < DepthW);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StLoad;
                    count_d = '0;
                end
            end
            StLoad: begin
                // A restart wins over a beat; an already registered write is unaffected.
                if (start) begin
                    count_d = '0;
                end else if (accept) begin
                    if (legal) begin
                        we_d    = 1'b1;
                        addr_d  = count_q[ADDR_W-1:0];
                        wdata_d = enc;
                        count_d = count_q + 1'b1;
                        if (last) state_d = StDone;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign ins_count  = count_q;
    assign busy       = (state_q == StLoad);
    assign done       = (state_q == StDone);
    assign err        = (state_q == StErr);

endmodule

// File: tb/tb_ins_encoder.sv
// Self-checking bench for ins_encoder: directed cases plus randomized beats compared
// cycle by cycle against a table-driven reference model.
module tb_ins_encoder;

    localparam int AW = 2;
    localparam int DP = 4;

    // Reference tables indexed by one-hot bit position.
    localparam int RFUNC [17] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 4, 6, 7, 8};
    localparam int IOP   [12] = '{8, 9, 12, 13, 14, 35, 43, 4, 5, 10, 11, 15};

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   code = 32'd0;
    logic [4:0]    rs = 5'd0, rt = 5'd0, rd = 5'd0, shamt = 5'd0;
    logic [15:0]   imm = 16'd0;
    logic [25:0]   target = 26'd0;
    logic          last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   ins_count;
    logic          busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model state: mode 0 idle, 1 loading, 2 finished, 3 error.
    int          m_mode = 0;
    int          m_count = 0;
    bit          m_we = 1'b0;
    int          m_addr = 0;
    logic [31:0] m_wdata = 32'd0;

    ins_encoder #(.ADDR_W(AW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .code(code), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
        .last(last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .ins_count(ins_count), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%08h expected 0x%08h", tag, cyc, got, exp);
        end
    endtask

    function automatic int code_index(input logic [31:0] c);
        if ($countones(c) != 1 || c[31]) return -1;
        for (int i = 0; i < 31; i++) if (c[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] ref_word(input int idx);
        logic [31:0] s, t, d, sh, w;
        s = 32'(rs); t = 32'(rt); d = 32'(rd); sh = 32'(shamt);
        if (idx <= 16) begin
            if (idx >= 10 && idx <= 12) s = 0;
            else sh = 0;
            if (idx == 16) begin t = 0; d = 0; end
            w = (s << 21) | (t << 16) | (d << 11) | (sh << 6) | 32'(RFUNC[idx]);
        end else if (idx <= 28) begin
            if (idx == 28) s = 0;
            w = (32'(IOP[idx - 17]) << 26) | (s << 21) | (t << 16) | 32'(imm);
        end else begin
            w = (32'(idx - 27) << 26) | 32'(target);
        end
        return w;
    endfunction

    task automatic tick();
        int idx;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_mode = 0; m_count = 0; m_we = 0; m_addr = 0; m_wdata = 0;
        end else begin
            m_we = 0;
            if (start) begin
                m_mode = 1; m_count = 0;
            end else if (m_mode == 1 && in_valid && m_count < DP) begin
                idx = code_index(code);
                if (idx < 0) m_mode = 3;
                else begin
                    m_we = 1; m_addr = m_count; m_wdata = ref_word(idx); m_count++;
                    if (last) m_mode = 2;
                end
            end
        end
        #1;
        check("in_ready", 32'(in_ready), 32'(m_mode == 1 && m_count < DP));
        check("busy", 32'(busy), 32'(m_mode == 1));
        check("done", 32'(done), 32'(m_mode == 2));
        check("err", 32'(err), 32'(m_mode == 3));
        check("imem_we", 32'(imem_we), 32'(m_we));
        check("imem_addr", 32'(imem_addr), 32'(m_addr));
        check("imem_wdata", imem_wdata, m_wdata);
        check("ins_count", 32'(ins_count), 32'(m_count));
    endtask

    task automatic idle();
        in_valid = 0; start = 0; rst = 0; last = 0;
    endtask

    task automatic do_start();
        idle(); start = 1; tick(); start = 0;
    endtask

    task automatic beat(input int bit_i, input logic [31:0] raw, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] c, input logic [4:0] sh,
                        input logic [15:0] im, input logic [25:0] tg, input logic lst);
        code = (bit_i >= 0) ? (32'd1 << bit_i) : raw;
        rs = a; rt = b; rd = c; shamt = sh; imm = im; target = tg; last = lst;
        in_valid = 1; start = 0; rst = 0;
    endtask

    initial begin
        rst = 1; tick(); tick();
        rst = 0; tick();
        check("reset_ready", 32'(in_ready), 32'd0);
        check("reset_wdata", imem_wdata, 32'd0);

        do_start();
        beat(0, 0, 5'd1, 5'd2, 5'd3, 5'd9, 16'h1234, 26'h0, 1'b1); tick(); idle();
        check("add_word", imem_wdata, 32'h00221820);
        check("add_done", 32'(done), 32'd1);
        tick();

        do_start();
        beat(10, 0, 5'd7, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0, 1'b0); tick();
        check("sll_word", imem_wdata, 32'h00021900);
        beat(13, 0, 5'd1, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0, 1'b1); tick(); idle();
        check("sllv_word", imem_wdata, 32'h00221804);
        check("sllv_addr", 32'(imem_addr), 32'd1);
        tick();

        do_start();
        beat(22, 0, 5'd29, 5'd8, 5'd0, 5'd0, 16'hfffc, 26'h0, 1'b0); tick();
        check("lw_word", imem_wdata, 32'h8fa8fffc);
        beat(29, 0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000, 1'b0); tick();
        check("j_word", imem_wdata, 32'h08100000);
        beat(30, 0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3ffffff, 1'b1); tick(); idle();
        check("jal_word", imem_wdata, 32'h0fffffff);
        check("jal_addr", 32'(imem_addr), 32'd2);
        check("jal_done", 32'(done), 32'd1);
        tick();

        do_start();
        beat(-1, 32'h3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0); tick(); idle();
        check("illegal_err", 32'(err), 32'd1);
        check("illegal_we", 32'(imem_we), 32'd0);
        do_start();
        check("restart_err", 32'(err), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);

        for (int i = 0; i < 6; i++) begin
            beat(i, 0, 5'(i), 5'(i + 1), 5'(i + 2), 5'd0, 16'h0, 26'h0, 1'b0); tick();
        end
        idle();
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_count", 32'(ins_count), 32'd4);
        check("full_busy", 32'(busy), 32'd1);
        do_start();
        check("refill_count", 32'(ins_count), 32'd0);
        check("refill_ready", 32'(in_ready), 32'd1);

        beat(1, 0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1'b0); rst = 1; tick(); idle();
        check("rst_drop_we", 32'(imem_we), 32'd0);
        check("rst_drop_count", 32'(ins_count), 32'd0);
        do_start();
        beat(2, 0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 1'b0); tick();
        idle(); rst = 1; tick(); idle();
        check("rst_after_we", 32'(imem_we), 32'd0);
        check("rst_after_wdata", imem_wdata, 32'd0);

        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            idle();
            if (r < 3) rst = 1;
            else if (r < 12) start = 1;
            else if (r < 80) begin
                if ($urandom_range(0, 99) < 88) code = 32'd1 << $urandom_range(0, 30);
                else code = $urandom();
                rs = 5'($urandom()); rt = 5'($urandom()); rd = 5'($urandom());
                shamt = 5'($urandom()); imm = 16'($urandom()); target = 26'($urandom());
                last = ($urandom_range(0, 99) < 20);
                in_valid = 1;
            end
            tick();
        end
        idle(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
